// File: rtl/can_rx_drain_ctrl.sv
// +----------------------------------------------------------------------------+
// | can_rx_drain_ctrl: pops the CAN RX FIFO head into a host-readable snapshot |
// | and raises the receive interrupt. Optional retry: CAN_RX_RETRY_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module can_rx_drain_ctrl (
  input  logic        clk,
  input  logic        nRST,
  input  logic        clear,
  input  logic        pop_req,
  input  logic        fifo_empty,
  input  logic [3:0]  fifo_occupancy,
  input  logic        fifo_overrun,
  input  logic        fifo_read,
  input  logic [28:0] id_in,
  input  logic [31:0] data_l_in,
  input  logic [31:0] data_h_in,
  input  logic [3:0]  pkt_size_in,
  input  logic        rtr_in,
  input  logic        ext_in,
  input  logic [4:0]  fmi_in,
  input  logic [3:0]  watermark,
  input  logic [2:0]  irq_mask,
  input  logic [2:0]  irq_ack,
  input  logic [1:0]  rd_sel,
  output logic        read_fifo,
  output logic        busy,
  output logic        frame_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  irq_status,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    SETTLE1 = 3'd3,
    SETTLE2 = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        read_fifo_nxt;
  logic        load_snap;
  logic        clr_valid;
  logic        set_valid;
  logic        pop_err;

  logic [28:0] snap_id;
  logic [31:0] snap_data_l;
  logic [31:0] snap_data_h;
  logic [3:0]  snap_pkt_size;
  logic        snap_rtr;
  logic        snap_ext;
  logic [4:0]  snap_fmi;

  logic        overrun_q;
  logic [3:0]  wm_eff;
  logic [2:0]  status_set;

`ifdef CAN_RX_RETRY_EN
  logic [2:0]  retry_cnt, retry_cnt_nxt;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)      state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    read_fifo_nxt = 1'b0;
    load_snap     = 1'b0;
    clr_valid     = 1'b0;
    set_valid     = 1'b0;
    pop_err       = 1'b0;
`ifdef CAN_RX_RETRY_EN
    retry_cnt_nxt = retry_cnt;
`endif
    case (state)
      IDLE: begin
        if (pop_req) begin
          clr_valid = 1'b1;
          if (!fifo_empty) begin
            load_snap     = 1'b1;
            read_fifo_nxt = 1'b1;
            state_nxt     = REQ;
`ifdef CAN_RX_RETRY_EN
            retry_cnt_nxt = 3'd0;
`endif
          end
        end
      end
      REQ: state_nxt = WAIT;
      WAIT: begin
        if (fifo_read) begin
          state_nxt = SETTLE1;
`ifdef CAN_RX_RETRY_EN
          retry_cnt_nxt = 3'd0;
`endif
        end else begin
`ifdef CAN_RX_RETRY_EN
          // Initial attempt plus four retries; the fifth failure gives up.
          if (retry_cnt < 3'd4) begin
            retry_cnt_nxt = retry_cnt + 3'd1;
            read_fifo_nxt = 1'b1;
            state_nxt     = REQ;
          end else begin
            pop_err   = 1'b1;
            state_nxt = IDLE;
          end
`else
          pop_err   = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      SETTLE1: state_nxt = SETTLE2;
      SETTLE2: begin
        set_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      read_fifo     <= 1'b0;
      frame_valid   <= 1'b0;
      snap_id       <= '0;
      snap_data_l   <= '0;
      snap_data_h   <= '0;
      snap_pkt_size <= '0;
      snap_rtr      <= 1'b0;
      snap_ext      <= 1'b0;
      snap_fmi      <= '0;
    end else if (clear) begin
      read_fifo     <= 1'b0;
      frame_valid   <= 1'b0;
      snap_id       <= '0;
      snap_data_l   <= '0;
      snap_data_h   <= '0;
      snap_pkt_size <= '0;
      snap_rtr      <= 1'b0;
      snap_ext      <= 1'b0;
      snap_fmi      <= '0;
    end else begin
      read_fifo <= read_fifo_nxt;
      if (set_valid)      frame_valid <= 1'b1;
      else if (clr_valid) frame_valid <= 1'b0;
      if (load_snap) begin
        snap_id       <= id_in;
        snap_data_l   <= data_l_in;
        snap_data_h   <= data_h_in;
        snap_pkt_size <= pkt_size_in;
        snap_rtr      <= rtr_in;
        snap_ext      <= ext_in;
        snap_fmi      <= fmi_in;
      end
    end
  end

`ifdef CAN_RX_RETRY_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)      retry_cnt <= 3'd0;
    else if (clear) retry_cnt <= 3'd0;
    else            retry_cnt <= retry_cnt_nxt;
  end
`endif

  // Edge detector tracks the raw flag even through clear.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) overrun_q <= 1'b0;
    else       overrun_q <= fifo_overrun;
  end

  assign wm_eff     = (watermark == 4'd0) ? 4'd1 : watermark;
  assign status_set = {pop_err,
                       fifo_overrun & ~overrun_q,
                       (fifo_occupancy >= wm_eff)};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)      irq_status <= 3'b000;
    else if (clear) irq_status <= 3'b000;
    else            irq_status <= (irq_status & ~irq_ack) | status_set;
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_sel)
      2'd0:    rd_data = {3'b000, snap_id};
      2'd1:    rd_data = {19'd0, snap_fmi, 2'b00, snap_rtr, snap_ext, snap_pkt_size};
      2'd2:    rd_data = snap_data_l;
      default: rd_data = snap_data_h;
    endcase
  end

  assign busy = (state != IDLE);
  assign irq  = |(irq_status & irq_mask);

endmodule

`default_nettype wire

// File: doc/can_rx_drain_ctrl.md
# can_rx_drain_ctrl

Sequencer that drains the CAN receive FIFO on behalf of the host bus. On a host pop request it snapshots the FIFO head frame, issues a single-cycle `read_fifo` pulse, confirms the pop via `fifo_read`, and exposes the snapshot as four 32-bit words. It also generates the receive interrupt from FIFO occupancy, overrun and pop-failure events. It sits between the host register interface and the receive FIFO.

## Interface
- No parameters.
- `clk` in 1 — clock.
- `nRST` in 1 — reset: asynchronous, active-low; clock is `clk`.
- `clear` in 1 — synchronous soft reset of FSM, snapshot and status.
- `pop_req` in 1 — host pop request; sampled only in IDLE.
- `fifo_empty` in 1 — FIFO empty flag.
- `fifo_occupancy` in 4 — FIFO occupancy, 0..8.
- `fifo_overrun` in 1 — FIFO overrun flag.
- `fifo_read` in 1 — FIFO pop acknowledge; high the cycle after a serviced `read_fifo`.
- `id_in` in 29, `data_l_in` in 32, `data_h_in` in 32, `pkt_size_in` in 4, `rtr_in` in 1, `ext_in` in 1, `fmi_in` in 5 — registered FIFO head outputs.
- `watermark` in 4 — pending threshold; 0 is treated as 1.
- `irq_mask` in 3 — interrupt enables, bit per status bit.
- `irq_ack` in 3 — write-1-to-clear pulses for `irq_status`.
- `rd_sel` in 2 — snapshot word select.
- `read_fifo` out 1 — registered pop strobe to the FIFO.
- `busy` out 1 — high whenever the FSM is not in IDLE.
- `frame_valid` out 1 — snapshot holds a successfully popped frame.
- `rd_data` out 32 — selected snapshot word (combinational from the snapshot).
- `irq_status` out 3 — [0] rx_pending, [1] overrun, [2] pop_err.
- `irq` out 1 — `|(irq_status & irq_mask)`.

## Operation
- Reset values: all outputs and internal registers are 0, and the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT, SETTLE1, SETTLE2.
- IDLE:
  - `pop_req & ~fifo_empty`: load the snapshot from the head inputs, clear `frame_valid`, set `read_fifo`, go to REQ.
  - `pop_req & fifo_empty`: ignored, `frame_valid` cleared, no status change.
- REQ: `read_fifo` is high for exactly this one cycle. Go to WAIT and clear `read_fifo`.
- WAIT:
  - `fifo_read=1`: go to SETTLE1, reset the retry counter.
  - Otherwise the pop was blocked (a FIFO write took priority): retry handling per Configuration.
- SETTLE1 -> SETTLE2 -> IDLE. On leaving SETTLE2, set `frame_valid=1`; the FIFO head outputs are stable again.
- `rd_data` by `rd_sel`:
  - 0: `{3'b0, id}`
  - 1: `{19'b0, fmi, 2'b0, rtr, ext, pkt_size}`
  - 2: `data_l`
  - 3: `data_h`
- `irq_status` bits are sticky:
  - [0] sets while `fifo_occupancy >= max(watermark,1)`.
  - [1] sets on a `fifo_overrun` rising edge.
  - [2] sets on pop failure.
  - `irq_ack` clears the acked bits; a set condition in the same cycle wins over ack.
  - [0] re-sets the next cycle if the condition persists.
- `clear`: highest priority below reset. FSM to IDLE; `read_fifo`, `frame_valid`, snapshot, retry counter and `irq_status` all to 0. `pop_req` in the same cycle is ignored.
- `pop_req` while `busy` is ignored and not queued.

## Timing
- Pop latency: `pop_req` sampled at edge N gives `read_fifo` high in cycle N+1, `fifo_read` expected in cycle N+2, and `frame_valid=1` from cycle N+5 on an unobstructed pop.
- `read_fifo` is never high on two consecutive cycles. This guarantees a single FIFO pop per request.
- The snapshot is taken from head outputs before the pop. It is not updated by later FIFO activity until the next accepted `pop_req`.
- `irq` is combinational from the registered `irq_status` and `irq_mask`.
- Overrun edge detection uses one registered copy of `fifo_overrun`. It detects 0->1 only; a constant-high flag raises at most one event.

## Configuration
- `CAN_RX_RETRY_EN` defined:
  - WAIT with no `fifo_read` returns to REQ (new one-cycle pulse) up to 4 retries.
  - When the 5th attempt fails: set `irq_status[2]`, leave `frame_valid=0`, go to IDLE.
- Undefined: the first WAIT without `fifo_read` sets `irq_status[2]` and goes to IDLE. No retry counter is built.

## Test plan
- Basic pop:
  - Stimulus: FIFO holding one frame (ID=0x1ABCDEF, size=8, data_L=0x11223344, data_H=0x55667788, fmi=3, ext=1), then `pop_req`.
  - Response: one `read_fifo` pulse. After `frame_valid`, `rd_sel`=0..3 read 0x01ABCDEF, 0x0000_0318, 0x11223344, 0x55667788.
- Empty pop: `pop_req` with `fifo_empty=1` -> no `read_fifo`, `busy` stays 0, `frame_valid=0`, `irq_status` unchanged.
- Blocked pop:
  - Stimulus: hold `fifo_read=0` for the first 2 attempts.
  - Response with `CAN_RX_RETRY_EN`: 3 `read_fifo` pulses separated by WAIT cycles, then `frame_valid=1`.
  - Response without it: `irq_status[2]=1` after the first WAIT.
- Watermark and overrun:
  - Stimulus: `watermark=4`, occupancy ramps 0..5, `irq_mask=3'b011`.
  - Response: `irq_status[0]` sets at occupancy 4.
  - Stimulus: overrun 0->1 while `irq_ack=3'b010` in the same cycle.
  - Response: bit 1 stays set and `irq=1`.
- Clear/reset mid-operation:
  - Stimulus: `clear` in WAIT.
  - Response: next cycle IDLE, `read_fifo=0`, `frame_valid=0`, `irq_status=0`.
  - Stimulus: `nRST` low in REQ.
  - Response: `read_fifo` drops immediately (asynchronously).
